// File: rtl/ripple_carry_adder_subtractor.sv
// WIDTH-bit two's-complement adder/subtractor built from a rippled chain of full adders,
// with a combinational result and a one-cycle registered copy that includes signed overflow.

module ripple_carry_adder_subtractor_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

module ripple_carry_adder_subtractor #(
  parameter int WIDTH = 4  // must be >= 2 so that a sign stage and a carry into it both exist
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;

  // Cin selects subtract: B is inverted and the same 1 supplies the +1 of the two's complement.
  assign w_carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    assign w_b[i] = B[i] ^ Cin;

    ripple_carry_adder_subtractor_fa u_fa (
      .i_a (A[i]),
      .i_b (w_b[i]),
      .i_c (w_carry[i]),
      .o_s (w_sum[i]),
      .o_c (w_carry[i+1])
    );
  end

  assign sum   = w_sum;
  assign cout  = w_carry[WIDTH];
  assign w_ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= w_sum;
      cout_q <= w_carry[WIDTH];
      ovf_q  <= w_ovf;
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder_subtractor.sv
// Directed and exhaustive self-checking bench for ripple_carry_adder_subtractor (WIDTH=4).

module tb_ripple_carry_adder_subtractor;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  int total = 0;
  int bad   = 0;

  ripple_carry_adder_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .Cin    (Cin),
    .sum    (sum),
    .cout   (cout),
    .sum_q  (sum_q),
    .cout_q (cout_q),
    .ovf_q  (ovf_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: returns {ovf, cout, sum}.
  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [4:0] r;
    logic [3:0] s;
    logic       co;
    logic       ov;
    if (!cin) begin
      r  = {1'b0, a} + {1'b0, b};
      s  = r[3:0];
      co = r[4];
      ov = (a[3] == b[3]) && (s[3] != a[3]);
    end else begin
      s  = a - b;
      co = (a >= b);
      ov = (a[3] != b[3]) && (s[3] != a[3]);
    end
    return {ov, co, s};
  endfunction

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic cin);
    @(negedge clk);
    A   = a;
    B   = b;
    Cin = cin;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] exp_v;

  initial begin
    rst = 1'b1;
    A   = 4'b0011;
    B   = 4'b0101;
    Cin = 1'b1;
    #2;
    chk("reset_sum_q",  {4'b0, sum_q}, 8'h00);
    chk("reset_cout_q", {7'b0, cout_q}, 8'h00);
    chk("reset_ovf_q",  {7'b0, ovf_q}, 8'h00);
    chk("reset_comb_sum",  {4'b0, sum}, 8'h0E);
    chk("reset_comb_cout", {7'b0, cout}, 8'h00);
    edge_wait();
    chk("reset_held_sum_q", {4'b0, sum_q}, 8'h00);

    @(negedge clk);
    rst = 1'b0;

    // -1 + 1 wraps to 0 with unsigned carry, no signed overflow
    drive(4'b1111, 4'b0001, 1'b0);
    chk("add_f_1_sum",  {4'b0, sum}, 8'h00);
    chk("add_f_1_cout", {7'b0, cout}, 8'h01);
    edge_wait();
    chk("add_f_1_sum_q",  {4'b0, sum_q}, 8'h00);
    chk("add_f_1_cout_q", {7'b0, cout_q}, 8'h01);
    chk("add_f_1_ovf_q",  {7'b0, ovf_q}, 8'h00);

    // -4 - 6 = -10 is outside [-8,7]: carries c4=1, c3=0 so overflow is set
    drive(4'b1100, 4'b0110, 1'b1);
    chk("sub_c_6_sum",  {4'b0, sum}, 8'h06);
    chk("sub_c_6_cout", {7'b0, cout}, 8'h01);
    edge_wait();
    chk("sub_c_6_ovf_q", {7'b0, ovf_q}, 8'h01);

    drive(4'b0011, 4'b0101, 1'b1);
    chk("sub_3_5_sum",  {4'b0, sum}, 8'h0E);
    chk("sub_3_5_cout", {7'b0, cout}, 8'h00);
    edge_wait();
    chk("sub_3_5_sum_q", {4'b0, sum_q}, 8'h0E);
    chk("sub_3_5_ovf_q", {7'b0, ovf_q}, 8'h00);

    drive(4'b0111, 4'b0001, 1'b0);
    chk("add_7_1_sum",  {4'b0, sum}, 8'h08);
    chk("add_7_1_cout", {7'b0, cout}, 8'h00);
    edge_wait();
    chk("add_7_1_ovf_q", {7'b0, ovf_q}, 8'h01);

    drive(4'b1000, 4'b0001, 1'b1);
    chk("sub_8_1_sum",  {4'b0, sum}, 8'h07);
    chk("sub_8_1_cout", {7'b0, cout}, 8'h01);
    edge_wait();
    chk("sub_8_1_sum_q",  {4'b0, sum_q}, 8'h07);
    chk("sub_8_1_cout_q", {7'b0, cout_q}, 8'h01);
    chk("sub_8_1_ovf_q",  {7'b0, ovf_q}, 8'h01);

    // mid-cycle reset clears registers at once; comb path stays live
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_sum_q",  {4'b0, sum_q}, 8'h00);
    chk("midrst_cout_q", {7'b0, cout_q}, 8'h00);
    chk("midrst_ovf_q",  {7'b0, ovf_q}, 8'h00);
    A   = 4'b0101;
    B   = 4'b0010;
    Cin = 1'b0;
    #1;
    chk("midrst_comb_sum",  {4'b0, sum}, 8'h07);
    chk("midrst_comb_cout", {7'b0, cout}, 8'h00);
    edge_wait();
    chk("midrst_edge_sum_q", {4'b0, sum_q}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst_pre_edge_sum_q", {4'b0, sum_q}, 8'h00);
    edge_wait();
    chk("postrst_sum_q",  {4'b0, sum_q}, 8'h07);
    chk("postrst_cout_q", {7'b0, cout_q}, 8'h00);
    chk("postrst_ovf_q",  {7'b0, ovf_q}, 8'h00);

    // exhaustive sweep of both modes, combinational and registered
    for (int cin = 0; cin < 2; cin++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          exp_v = model(a[3:0], b[3:0], cin[0]);
          drive(a[3:0], b[3:0], cin[0]);
          chk($sformatf("sweep_comb a=%0h b=%0h cin=%0d", a, b, cin),
              {3'b0, cout, sum}, {3'b0, exp_v[4:0]});
          edge_wait();
          chk($sformatf("sweep_reg a=%0h b=%0h cin=%0d", a, b, cin),
              {2'b0, ovf_q, cout_q, sum_q}, {2'b0, exp_v});
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
